subblk_to_pang_packer: RTL and testbench
========================================

// Module: subblk_to_pang_packer
// PURPOSE
// - Write-side counterpart of the pang sub-block extractor: packs a byte stream of sub-blocks into
//   16-entry ping/pang blocks and presents each completed block as z00..z15 with needfull/start/end incs.
// - Sits upstream of the per-pang extractor; the extractor consumes a block and returns blko_ack.
// - Double-buffered (ping, pang) so one block fills while the other is held for the consumer.
// PARAMETERS
// - DW    8   sub-block width in bits
// - NSUB  16  sub-blocks per block (power of 2)
// - SFTW  4   log2(NSUB); width of index/inc fields
// PORTS
// - clk            in   1         clock; all logic on posedge
// - reset          in   1         synchronous, active-high reset
// - subblki        in   DW        incoming sub-block
// - subblki_valid  in   1         subblki present this cycle
// - subblki_ready  out  1         packer accepts subblki this cycle (transfer = valid & ready)
// - blk_start_sft  in   SFTW      slot of first sub-block of a new block; sampled on its first transfer
// - flush          in   1         close current partially filled block
// - blko           out  DW*NSUB   held block; slot k at [DW*k +: DW] (slot 0 = z00)
// - blko_needfull  out  1         held block valid for consumer
// - blko_startinc  out  SFTW      first valid slot of held block
// - blko_endinc    out  SFTW      last valid slot of held block
// - blko_ack       in   1         consumer done with held block; ignored when blko_needfull=0
// BEHAVIOUR
// - Per buffer state: EMPTY -> FILLING (first transfer) -> FULL (slot NSUB-1 written, or flush) -> EMPTY (ack).
// - wr_sel selects buffer being filled, rd_sel buffer being presented; both toggle ping<->pang, start at ping.
// - subblki_ready = ~reset & (buffer[wr_sel] != FULL); registered-state only, no comb path from blko_ack.
// - First transfer into EMPTY buffer: slot = blk_start_sft, startinc latched = blk_start_sft; later transfers
//   slot = previous+1. Slots never written read as 0 (buffer cleared on release).
// - Transfer to slot NSUB-1: buffer -> FULL, endinc = NSUB-1, wr_sel toggles, next block starts fresh.
// - flush with buffer FILLING: buffer -> FULL, endinc = last written slot; a same-cycle transfer is included
//   first (endinc = its slot). flush with buffer EMPTY and no transfer: no-op, no empty block emitted.
// - flush while buffer[wr_sel] FULL: ignored (nothing open).
// - Latency: block closes at cycle t -> blko/blko_needfull/incs valid from t+1 (registered), held stable
//   until blko_ack sampled high; on ack buffer cleared to 0, rd_sel toggles, next FULL block shows at t+1.
// - Simultaneous ack of buffer X and ready=0 because wr_sel=X: write into X allowed from next cycle only.
// - Ordering: blocks presented strictly in closure order; both FULL -> ready=0, input stalls, no data lost.
// - start_sft > NSUB-1 impossible by width; a block may legally hold one sub-block (start=end).
// - reset: all buffers EMPTY and zeroed, wr_sel=rd_sel=ping, blko=0, blko_needfull=0, startinc=endinc=0,
//   subblki_ready=0 while reset high, 1 on first cycle after; reset mid-fill discards partial block.
// STRUCTURE
// - Shared package: DW/NSUB/SFTW constants, buffer state enum {EMPTY,FILLING,FULL}, ping/pang select consts.
// - One sub-module natural: pang_blk_buf (one 16xDW buffer + state + start/end/wr pointer, write/close/
//   clear ports); instantiated twice; top holds wr_sel/rd_sel, ready and output mux.
// TESTING
// - 16 bytes 0x00..0x0F, start_sft=0 -> cycle after 16th: needfull=1, z00=0x00..z15=0x0F, start=0, end=15.
// - 32 bytes back-to-back, no ack -> ready=0 after 32nd; ack -> second block (0x10..0x1F) next cycle.
// - 5 bytes 0xA0..0xA4 then flush -> z00..z04=0xA0..0xA4, z05..z15=0, start=0, end=4.
// - start_sft=3, 13 bytes 0xB0..0xBC -> z00..z02=0, z03=0xB0, z15=0xBC, start=3, end=15.
// - flush on cycle of 7th byte 0xC6 -> end=6 includes 0xC6; flush with empty buffer -> needfull stays 0.
// - reset after 9 bytes -> needfull=0, blko=0; next 16 bytes form a clean block starting z00.

Source files
------------

// File: rtl/subblk_to_pang_packer_pkg.sv
// Shared constants and types for the ping/pang sub-block packer.
package subblk_to_pang_packer_pkg;

  localparam int DW   = 8;
  localparam int NSUB = 16;
  localparam int SFTW = 4;

  localparam logic [SFTW-1:0] LAST_SLOT = SFTW'(NSUB - 1);

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_FULL
  } buf_state_e;

  localparam logic SEL_PING = 1'b0;
  localparam logic SEL_PANG = 1'b1;

endpackage

// File: rtl/subblk_to_pang_packer_pang_blk_buf.sv
// One NSUB x DW block buffer: fills slot by slot, closes on last slot or close
// request, and is wiped back to zero when the consumer releases it.
module pang_blk_buf
  import subblk_to_pang_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DW-1:0]        wr_data,
  input  logic [SFTW-1:0]      start_sft,
  input  logic                 close_req,
  input  logic                 clear,
  output buf_state_e           state,
  output logic [DW*NSUB-1:0]   data,
  output logic [SFTW-1:0]      startinc,
  output logic [SFTW-1:0]      endinc,
  output logic                 closing
);

  buf_state_e      state_next;
  logic [SFTW-1:0] wr_ptr;
  logic [SFTW-1:0] slot;
  logic            accept;

  // The first write lands at the requested start slot; later writes follow on.
  always_comb begin
    state_next = state;
    closing    = 1'b0;
    slot       = (state == BUF_EMPTY) ? start_sft : wr_ptr + SFTW'(1);
    accept     = wr_en && (state != BUF_FULL);
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          if (slot == LAST_SLOT || close_req) begin
            state_next = BUF_FULL;
            closing    = 1'b1;
          end else begin
            state_next = BUF_FILLING;
          end
        end
      end
      BUF_FILLING: begin
        if ((accept && slot == LAST_SLOT) || close_req) begin
          state_next = BUF_FULL;
          closing    = 1'b1;
        end
      end
      BUF_FULL: begin
        if (clear) state_next = BUF_EMPTY;
      end
      default: state_next = BUF_EMPTY;
    endcase
  end

  // A same-cycle write is folded in before closing, so endinc tracks it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BUF_EMPTY;
      data     <= '0;
      startinc <= '0;
      endinc   <= '0;
      wr_ptr   <= '0;
    end else begin
      state <= state_next;
      if (clear && state == BUF_FULL) begin
        data     <= '0;
        startinc <= '0;
        endinc   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (accept) begin
          data[slot*DW +: DW] <= wr_data;
          wr_ptr              <= slot;
          if (state == BUF_EMPTY) startinc <= start_sft;
        end
        if (closing) endinc <= accept ? slot : wr_ptr;
      end
    end
  end

endmodule

// File: rtl/subblk_to_pang_packer.sv
// Packs a sub-block byte stream into double-buffered 16-slot blocks and presents
// completed blocks to the downstream extractor in closure order.
module subblk_to_pang_packer
  import subblk_to_pang_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW-1:0]        subblki,
  input  logic                 subblki_valid,
  output logic                 subblki_ready,
  input  logic [SFTW-1:0]      blk_start_sft,
  input  logic                 flush,
  output logic [DW*NSUB-1:0]   blko,
  output logic                 blko_needfull,
  output logic [SFTW-1:0]      blko_startinc,
  output logic [SFTW-1:0]      blko_endinc,
  input  logic                 blko_ack
);

  logic                wr_sel;
  logic                rd_sel;
  logic                transfer;
  buf_state_e          buf_state [2];
  logic [DW*NSUB-1:0]  buf_data  [2];
  logic [SFTW-1:0]     buf_start [2];
  logic [SFTW-1:0]     buf_end   [2];
  logic                buf_closing [2];

  assign subblki_ready = ~reset & (buf_state[wr_sel] != BUF_FULL);
  assign transfer      = subblki_valid & subblki_ready;
  assign blko_needfull = (buf_state[rd_sel] == BUF_FULL);

  for (genvar i = 0; i < 2; i++) begin : g_buf
    pang_blk_buf u_buf (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (transfer && (wr_sel == 1'(i))),
      .wr_data   (subblki),
      .start_sft (blk_start_sft),
      .close_req (flush && (wr_sel == 1'(i))),
      .clear     (blko_ack && blko_needfull && (rd_sel == 1'(i))),
      .state     (buf_state[i]),
      .data      (buf_data[i]),
      .startinc  (buf_start[i]),
      .endinc    (buf_end[i]),
      .closing   (buf_closing[i])
    );
  end

  // Writer moves on once its block closes; reader moves on once its block is acked.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel <= SEL_PING;
      rd_sel <= SEL_PING;
    end else begin
      if (buf_closing[wr_sel]) wr_sel <= ~wr_sel;
      if (blko_ack && blko_needfull) rd_sel <= ~rd_sel;
    end
  end

  always_comb begin
    blko          = '0;
    blko_startinc = '0;
    blko_endinc   = '0;
    if (blko_needfull) begin
      blko          = buf_data[rd_sel];
      blko_startinc = buf_start[rd_sel];
      blko_endinc   = buf_end[rd_sel];
    end
  end

endmodule

// File: tb/tb_subblk_to_pang_packer.sv
// Directed self-checking bench for the ping/pang sub-block packer.
module tb_subblk_to_pang_packer;
  import subblk_to_pang_packer_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [DW-1:0]       subblki;
  logic                subblki_valid;
  logic                subblki_ready;
  logic [SFTW-1:0]     blk_start_sft;
  logic                flush;
  logic [DW*NSUB-1:0]  blko;
  logic                blko_needfull;
  logic [SFTW-1:0]     blko_startinc;
  logic [SFTW-1:0]     blko_endinc;
  logic                blko_ack;

  int vectors     = 0;
  int miscompares = 0;

  subblk_to_pang_packer dut (
    .clk           (clk),
    .reset         (reset),
    .subblki       (subblki),
    .subblki_valid (subblki_valid),
    .subblki_ready (subblki_ready),
    .blk_start_sft (blk_start_sft),
    .flush         (flush),
    .blko          (blko),
    .blko_needfull (blko_needfull),
    .blko_startinc (blko_startinc),
    .blko_endinc   (blko_endinc),
    .blko_ack      (blko_ack)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [DW*NSUB-1:0] observed,
                              input logic [DW*NSUB-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_block(input string tag, input logic [DW*NSUB-1:0] exp_blk,
                             input logic [SFTW-1:0] exp_start, input logic [SFTW-1:0] exp_end);
    check_output({tag, "_needfull"}, 128'(blko_needfull), 128'(1));
    check_output({tag, "_blko"}, blko, exp_blk);
    check_output({tag, "_start"}, 128'(blko_startinc), 128'(exp_start));
    check_output({tag, "_end"}, 128'(blko_endinc), 128'(exp_end));
  endtask

  // One cycle of stimulus; outputs are then sampled 1ns after the edge.
  task automatic apply_stimulus(input logic vld, input logic [DW-1:0] d,
                                input logic [SFTW-1:0] sft, input logic fl);
    subblki_valid = vld;
    subblki       = d;
    blk_start_sft = sft;
    flush         = fl;
    @(posedge clk);
    #1;
    subblki_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic ack_block();
    blko_ack = 1'b1;
    @(posedge clk);
    #1;
    blko_ack = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    subblki       = '0;
    subblki_valid = 1'b0;
    blk_start_sft = '0;
    flush         = 1'b0;
    blko_ack      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ready", 128'(subblki_ready), 128'(0));
    check_output("rst_needfull", 128'(blko_needfull), 128'(0));
    check_output("rst_blko", blko, 128'(0));
    check_output("rst_start", 128'(blko_startinc), 128'(0));
    check_output("rst_end", 128'(blko_endinc), 128'(0));
    reset = 1'b0;
    #1;
    check_output("post_rst_ready", 128'(subblki_ready), 128'(1));

    $display("[TB] full block 0x00..0x0F");
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 8'(i), 4'd0, 1'b0);
    check_block("blk16", 128'h0F0E0D0C0B0A09080706050403020100, 4'd0, 4'd15);
    check_output("blk16_ready", 128'(subblki_ready), 128'(1));
    ack_block();
    check_output("blk16_released", 128'(blko_needfull), 128'(0));
    check_output("blk16_cleared", blko, 128'(0));

    $display("[TB] 32 bytes back-to-back, no ack");
    for (int i = 0; i < 32; i++) apply_stimulus(1'b1, 8'(i), 4'd0, 1'b0);
    check_output("both_full_ready", 128'(subblki_ready), 128'(0));
    check_block("b2b_first", 128'h0F0E0D0C0B0A09080706050403020100, 4'd0, 4'd15);
    apply_stimulus(1'b1, 8'h55, 4'd0, 1'b0);
    check_block("stall_hold", 128'h0F0E0D0C0B0A09080706050403020100, 4'd0, 4'd15);
    ack_block();
    check_block("b2b_second", 128'h1F1E1D1C1B1A19181716151413121110, 4'd0, 4'd15);
    check_output("b2b_ready_after_ack", 128'(subblki_ready), 128'(1));
    ack_block();
    check_output("b2b_drained", 128'(blko_needfull), 128'(0));

    $display("[TB] flush after 5 bytes");
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 8'hA0 + 8'(i), 4'd0, 1'b0);
    check_output("pre_flush_needfull", 128'(blko_needfull), 128'(0));
    apply_stimulus(1'b0, 8'h00, 4'd0, 1'b1);
    check_block("flush5", 128'h0000000000000000000000A4A3A2A1A0, 4'd0, 4'd4);
    ack_block();

    $display("[TB] start_sft=3");
    for (int i = 0; i < 13; i++) apply_stimulus(1'b1, 8'hB0 + 8'(i), 4'd3, 1'b0);
    check_block("sft3", 128'hBCBBBAB9B8B7B6B5B4B3B2B1B0000000, 4'd3, 4'd15);
    ack_block();

    $display("[TB] flush on the 7th byte");
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 8'hC0 + 8'(i), 4'd0, 1'b0);
    apply_stimulus(1'b1, 8'hC6, 4'd0, 1'b1);
    check_block("flush_same", 128'h000000000000000000C6C5C4C3C2C1C0, 4'd0, 4'd6);
    ack_block();
    apply_stimulus(1'b0, 8'h00, 4'd0, 1'b1);
    check_output("empty_flush_1", 128'(blko_needfull), 128'(0));
    apply_stimulus(1'b0, 8'h00, 4'd0, 1'b0);
    check_output("empty_flush_2", 128'(blko_needfull), 128'(0));

    $display("[TB] single sub-block at slot 9");
    apply_stimulus(1'b1, 8'h77, 4'd9, 1'b1);
    check_block("single", 128'h00000000000077000000000000000000, 4'd9, 4'd9);
    ack_block();

    $display("[TB] reset mid-fill");
    for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 8'hD0 + 8'(i), 4'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("midrst_needfull", 128'(blko_needfull), 128'(0));
    check_output("midrst_blko", blko, 128'(0));
    for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 8'h20 + 8'(i), 4'd0, 1'b0);
    check_block("after_rst", 128'h2F2E2D2C2B2A29282726252423222120, 4'd0, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
